ipv4_deframer: RTL and testbench

//  Strips IPv4 header from a 4-byte-wide AXIS Ethernet-payload stream; forwards IP payload (TCP segment) to tcp_deframer.

---
 rtl/ip_pkg.sv | 37 +++
 rtl/ip_csum_acc.sv | 32 +++
 rtl/ipv4_deframer.sv | 181 ++++++++++++++++++
 tb/tb_ipv4_deframer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ip_pkg.sv
// Shared types and helpers for the IPv4 deframer.
// Header field constants, FSM states and byte-order utilities.
package ip_pkg;

    typedef enum logic [1:0] {
        HEADER,
        PAYLOAD,
        TRIM,
        DROP
    } state_e;

    localparam int         AXIS_BYTES   = 4;
    localparam logic [3:0] IPV4_VERSION = 4'd4;
    localparam logic [3:0] IP_MIN_IHL   = 4'd5;
    localparam logic [7:0] IP_PROTO_TCP = 8'd6;

    function automatic logic [15:0] swap16(input logic [15:0] v);
        return {v[7:0], v[15:8]};
    endfunction

    function automatic logic [31:0] swap32(input logic [31:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction

    // Byte enables for a final beat holding 1..4 valid bytes
    function automatic logic [3:0] keep_mask(input logic [2:0] rem);
        logic [3:0] m;
        case (rem)
            3'd1:    m = 4'b0001;
            3'd2:    m = 4'b0011;
            3'd3:    m = 4'b0111;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ip_csum_acc.sv
// Running ones-complement sum of 16-bit halfwords, one 32-bit word per beat.
// sum_o already includes word_i so a check can be made on the same beat.
module ip_csum_acc (
    input  logic        clk,
    input  logic        sreset,
    input  logic        clr_i,
    input  logic        en_i,
    input  logic [31:0] word_i,
    output logic [15:0] sum_o
);

    logic [15:0] acc_q;
    logic [17:0] raw;
    logic [16:0] fold1;

    always_comb begin
        raw   = {2'b00, acc_q}
              + {2'b00, word_i[15:0]}
              + {2'b00, word_i[31:16]};
        fold1 = {1'b0, raw[15:0]} + {15'd0, raw[17:16]};
        sum_o = fold1[15:0] + {15'd0, fold1[16]};
    end

    always_ff @(posedge clk) begin
        if (sreset || clr_i) begin
            acc_q <= '0;
        end else if (en_i) begin
            acc_q <= sum_o;
        end
    end

endmodule

// File: rtl/ipv4_deframer.sv
// Strips the IPv4 header from a 32-bit AXIS stream and forwards the payload.
// Define IPV4_DEFRAMER_CHECKSUM_EN to drop packets with a bad header checksum.
module ipv4_deframer
    import ip_pkg::*;
#(
    parameter logic [7:0] PROTOCOL = IP_PROTO_TCP
) (
    input  logic        clk,
    input  logic        sreset,
    input  logic        axis_i_tvalid,
    output logic        axis_i_tready,
    input  logic [31:0] axis_i_tdata,
    input  logic [3:0]  axis_i_tkeep,
    input  logic        axis_i_tlast,
    output logic        axis_o_tvalid,
    input  logic        axis_o_tready,
    output logic [31:0] axis_o_tdata,
    output logic [3:0]  axis_o_tkeep,
    output logic        axis_o_tlast,
    output logic [15:0] axis_o_length_bytes,
    output logic [31:0] axis_o_src_ip,
    output logic [31:0] axis_o_dst_ip,
    output logic        drop_o,
    output logic        trunc_o
);

    state_e      state_q;
    logic [3:0]  ctr_q;
    logic [3:0]  ver_q;
    logic [3:0]  ihl_q;
    logic [15:0] tot_q;
    logic        frag_q;
    logic [7:0]  proto_q;
    logic [15:0] rem_q;
    logic [15:0] len_q;
    logic [31:0] src_q;
    logic [31:0] dst_q;
    logic        drop_q;
    logic        trunc_q;

    logic        in_hdr;
    logic        in_pay;
    logic        in_fire;
    logic        hdr_fire;
    logic [3:0]  ihl_cur;
    logic        decide;
    logic [15:0] hdr_bytes;
    logic        csum_bad;
    logic        bad;
    logic        last_beat;

    assign in_hdr   = (state_q == HEADER);
    assign in_pay   = (state_q == PAYLOAD);
    assign in_fire  = axis_i_tvalid && axis_i_tready;
    assign hdr_fire = in_hdr && in_fire;

    // IHL is only registered after word 0, so use the live nibble there
    assign ihl_cur   = (ctr_q == 4'd0) ? axis_i_tdata[3:0] : ihl_q;
    assign decide    = ({1'b0, ctr_q} + 5'd1) == {1'b0, ihl_cur};
    assign hdr_bytes = {10'd0, ihl_cur, 2'b00};

`ifdef IPV4_DEFRAMER_CHECKSUM_EN
    logic [15:0] csum_sum;
    logic        csum_clr;

    assign csum_clr = !in_hdr
                   || (hdr_fire && (axis_i_tlast || decide));

    ip_csum_acc u_csum (
        .clk    (clk),
        .sreset (sreset),
        .clr_i  (csum_clr),
        .en_i   (hdr_fire),
        .word_i (axis_i_tdata),
        .sum_o  (csum_sum)
    );

    assign csum_bad = (csum_sum != 16'hFFFF);
`else
    assign csum_bad = 1'b0;
`endif

    assign bad = (ver_q != IPV4_VERSION)
              || (ihl_cur < IP_MIN_IHL)
              || (proto_q != PROTOCOL)
              || frag_q
              || (tot_q <= hdr_bytes)
              || csum_bad;

    assign last_beat = (rem_q <= 16'(AXIS_BYTES));

    assign axis_i_tready = in_pay ? axis_o_tready : 1'b1;
    assign axis_o_tvalid = in_pay && axis_i_tvalid;
    assign axis_o_tdata  = axis_i_tdata;
    assign axis_o_tkeep  = last_beat ? keep_mask(rem_q[2:0])
                                     : axis_i_tkeep;
    assign axis_o_tlast  = last_beat || axis_i_tlast;

    assign axis_o_length_bytes = len_q;
    assign axis_o_src_ip       = src_q;
    assign axis_o_dst_ip       = dst_q;
    assign drop_o              = drop_q;
    assign trunc_o             = trunc_q;

    always_ff @(posedge clk) begin
        if (sreset) begin
            state_q <= HEADER;
            ctr_q   <= '0;
            ver_q   <= '0;
            ihl_q   <= '0;
            tot_q   <= '0;
            frag_q  <= 1'b0;
            proto_q <= '0;
            rem_q   <= '0;
            len_q   <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            drop_q  <= 1'b0;
            trunc_q <= 1'b0;
        end else begin
            drop_q  <= 1'b0;
            trunc_q <= 1'b0;
            case (state_q)
                HEADER: begin
                    if (in_fire) begin
                        ctr_q <= ctr_q + 4'd1;
                        case (ctr_q)
                            4'd0: begin
                                ver_q <= axis_i_tdata[7:4];
                                ihl_q <= axis_i_tdata[3:0];
                                tot_q <= swap16(axis_i_tdata[31:16]);
                            end
                            4'd1: begin
                                frag_q <= axis_i_tdata[21]
                                    || ({axis_i_tdata[20:16],
                                         axis_i_tdata[31:24]} != 13'd0);
                            end
                            4'd2: proto_q <= axis_i_tdata[15:8];
                            4'd3: src_q   <= swap32(axis_i_tdata);
                            4'd4: dst_q   <= swap32(axis_i_tdata);
                            default: ;
                        endcase
                        if (axis_i_tlast) begin
                            drop_q <= 1'b1;
                            ctr_q  <= '0;
                        end else if (decide) begin
                            ctr_q <= '0;
                            if (bad) begin
                                state_q <= DROP;
                                drop_q  <= 1'b1;
                            end else begin
                                state_q <= PAYLOAD;
                                rem_q   <= tot_q - hdr_bytes;
                                len_q   <= tot_q - hdr_bytes;
                            end
                        end
                    end
                end
                PAYLOAD: begin
                    if (in_fire) begin
                        if (last_beat) begin
                            state_q <= axis_i_tlast ? HEADER : TRIM;
                        end else if (axis_i_tlast) begin
                            trunc_q <= 1'b1;
                            state_q <= HEADER;
                        end else begin
                            rem_q <= rem_q - 16'(AXIS_BYTES);
                        end
                    end
                end
                TRIM, DROP: begin
                    if (in_fire && axis_i_tlast) begin
                        state_q <= HEADER;
                    end
                end
                default: state_q <= HEADER;
            endcase
        end
    end

endmodule

// File: tb/tb_ipv4_deframer.sv
// Directed bench for ipv4_deframer: good, padded, filtered,
// optioned, truncated, back-pressured and reset-interrupted packets.
module tb_ipv4_deframer;

    logic        clk = 1'b0;
    logic        sreset;
    logic        axis_i_tvalid;
    logic        axis_i_tready;
    logic [31:0] axis_i_tdata;
    logic [3:0]  axis_i_tkeep;
    logic        axis_i_tlast;
    logic        axis_o_tvalid;
    logic        axis_o_tready;
    logic [31:0] axis_o_tdata;
    logic [3:0]  axis_o_tkeep;
    logic        axis_o_tlast;
    logic [15:0] axis_o_length_bytes;
    logic [31:0] axis_o_src_ip;
    logic [31:0] axis_o_dst_ip;
    logic        drop_o;
    logic        trunc_o;

    always #5 clk = ~clk;

    ipv4_deframer dut (
        .clk                 (clk),
        .sreset              (sreset),
        .axis_i_tvalid       (axis_i_tvalid),
        .axis_i_tready       (axis_i_tready),
        .axis_i_tdata        (axis_i_tdata),
        .axis_i_tkeep        (axis_i_tkeep),
        .axis_i_tlast        (axis_i_tlast),
        .axis_o_tvalid       (axis_o_tvalid),
        .axis_o_tready       (axis_o_tready),
        .axis_o_tdata        (axis_o_tdata),
        .axis_o_tkeep        (axis_o_tkeep),
        .axis_o_tlast        (axis_o_tlast),
        .axis_o_length_bytes (axis_o_length_bytes),
        .axis_o_src_ip       (axis_o_src_ip),
        .axis_o_dst_ip       (axis_o_dst_ip),
        .drop_o              (drop_o),
        .trunc_o             (trunc_o)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    logic [36:0] obeats[$];
    int drops  = 0;
    int truncs = 0;

    always @(negedge clk) begin
        if (!sreset) begin
            if (axis_o_tvalid && axis_o_tready)
                obeats.push_back({axis_o_tlast, axis_o_tkeep, axis_o_tdata});
            if (drop_o)  drops++;
            if (trunc_o) truncs++;
        end
    end

    bit rand_rdy = 1'b0;

    initial begin
        axis_o_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) axis_o_tready = 1'($urandom_range(0, 1));
            else          axis_o_tready = 1'b1;
        end
    end

    logic [7:0] fb[$];
    int pay_off;

    task automatic build(input int ver, input int ihl, input int total,
                         input int proto, input int mf, input int nbytes,
                         input int seed, input bit bad_csum);
        int hl;
        logic [31:0] acc;
        logic [15:0] s;
        fb.delete();
        hl = (ihl < 5) ? 20 : ihl * 4;
        for (int i = 0; i < nbytes; i++) fb.push_back(8'((i * 7 + seed) & 255));
        for (int i = 20; i < hl; i++) fb[i] = 8'h00;
        fb[0]  = 8'(ver * 16 + ihl);
        fb[1]  = 8'h00;
        fb[2]  = 8'(total >> 8);
        fb[3]  = 8'(total);
        fb[4]  = 8'h12;
        fb[5]  = 8'h34;
        fb[6]  = (mf != 0) ? 8'h20 : 8'h00;
        fb[7]  = 8'h00;
        fb[8]  = 8'h40;
        fb[9]  = 8'(proto);
        fb[10] = 8'h00;
        fb[11] = 8'h00;
        fb[12] = 8'hC0; fb[13] = 8'hA8; fb[14] = 8'h01; fb[15] = 8'h0A;
        fb[16] = 8'h0A; fb[17] = 8'h00; fb[18] = 8'h00; fb[19] = 8'h05;
        acc = 0;
        for (int i = 0; i < hl; i += 2) acc += {16'd0, fb[i], fb[i+1]};
        acc = {16'd0, acc[15:0]} + {16'd0, acc[31:16]};
        acc = {16'd0, acc[15:0]} + {16'd0, acc[31:16]};
        s = ~acc[15:0];
        if (bad_csum) s = s ^ 16'h0001;
        fb[10] = s[15:8];
        fb[11] = s[7:0];
        pay_off = hl;
    endtask

    function automatic logic [31:0] fword(input int b);
        return {fb[b+3], fb[b+2], fb[b+1], fb[b]};
    endfunction

    task automatic send_word(input logic [31:0] d, input logic l);
        int n;
        axis_i_tvalid = 1'b1;
        axis_i_tdata  = d;
        axis_i_tkeep  = 4'hF;
        axis_i_tlast  = l;
        n = 0;
        forever begin
            @(negedge clk);
            if (axis_i_tready) break;
            n++;
            if (n > 200) begin
                check("tready_timeout", 32'd0, 32'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame();
        int nw;
        nw = fb.size() / 4;
        @(posedge clk);
        #1;
        for (int j = 0; j < nw; j++) send_word(fword(4 * j), j == nw - 1);
        axis_i_tvalid = 1'b0;
        axis_i_tlast  = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic check_pkt(input string tag, input int nb,
                             input logic [3:0] lkeep,
                             input int dd, input int dt);
        int n;
        check({tag, "_beats"}, obeats.size(), nb);
        n = (obeats.size() < nb) ? obeats.size() : nb;
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_data%0d", tag, i),
                  obeats[i][31:0], fword(pay_off + 4 * i));
            check($sformatf("%s_ctl%0d", tag, i),
                  {27'd0, obeats[i][36:32]},
                  (i == nb - 1) ? {27'd0, 1'b1, lkeep} : {27'd0, 5'h0F});
        end
        check({tag, "_drop"}, drops, dd);
        check({tag, "_trunc"}, truncs, dt);
        obeats.delete();
    endtask

    initial begin
        int d0;
        int t0;
        sreset        = 1'b1;
        axis_i_tvalid = 1'b0;
        axis_i_tdata  = '0;
        axis_i_tkeep  = '0;
        axis_i_tlast  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        sreset = 1'b0;
        @(negedge clk);
        check("rst_tready", {31'd0, axis_i_tready}, 32'd1);
        check("rst_tvalid", {31'd0, axis_o_tvalid}, 32'd0);
        check("rst_len", {16'd0, axis_o_length_bytes}, 32'd0);
        check("rst_src", axis_o_src_ip, 32'd0);
        check("rst_dst", axis_o_dst_ip, 32'd0);
        check("rst_pulses", {30'd0, drop_o, trunc_o}, 32'd0);

        d0 = drops; t0 = truncs;
        build(4, 5, 60, 6, 0, 60, 1, 0);
        send_frame();
        check_pkt("t1", 10, 4'hF, d0, t0);
        check("t1_len", {16'd0, axis_o_length_bytes}, 32'd40);
        check("t1_src", axis_o_src_ip, 32'hC0A8010A);
        check("t1_dst", axis_o_dst_ip, 32'h0A000005);

        build(4, 5, 46, 6, 0, 64, 2, 0);
        send_frame();
        check_pkt("t2", 7, 4'h3, d0, t0);
        check("t2_len", {16'd0, axis_o_length_bytes}, 32'd26);

        build(4, 5, 60, 17, 0, 60, 3, 0);
        send_frame();
        check_pkt("t3_proto", 0, 4'h0, d0 + 1, t0);
        build(4, 5, 60, 6, 1, 60, 3, 0);
        send_frame();
        check_pkt("t3_mf", 0, 4'h0, d0 + 2, t0);
        build(4, 4, 60, 6, 0, 60, 3, 0);
        send_frame();
        check_pkt("t3_ihl", 0, 4'h0, d0 + 3, t0);

        d0 = drops;
        build(4, 7, 48, 6, 0, 48, 4, 0);
        send_frame();
        check_pkt("t4", 5, 4'hF, d0, t0);
        check("t4_len", {16'd0, axis_o_length_bytes}, 32'd20);

        build(4, 5, 100, 6, 0, 52, 5, 0);
        send_frame();
        check_pkt("t5", 8, 4'hF, d0, t0 + 1);
        check("t5_len", {16'd0, axis_o_length_bytes}, 32'd80);
        t0 = truncs;
        build(4, 5, 60, 6, 0, 60, 6, 0);
        send_frame();
        check_pkt("t5_next", 10, 4'hF, d0, t0);

        rand_rdy = 1'b1;
        build(4, 5, 60, 6, 0, 60, 7, 0);
        send_frame();
        check_pkt("t6_bp", 10, 4'hF, d0, t0);

        build(4, 5, 60, 6, 0, 60, 8, 0);
        @(posedge clk);
        #1;
        for (int j = 0; j < 8; j++) send_word(fword(4 * j), 1'b0);
        axis_i_tvalid = 1'b0;
        sreset = 1'b1;
        @(posedge clk);
        #1;
        sreset = 1'b0;
        obeats.delete();
        d0 = drops; t0 = truncs;
        @(negedge clk);
        check("t6_rst_tready", {31'd0, axis_i_tready}, 32'd1);
        check("t6_rst_tvalid", {31'd0, axis_o_tvalid}, 32'd0);
        check("t6_rst_len", {16'd0, axis_o_length_bytes}, 32'd0);
        check("t6_rst_src", axis_o_src_ip, 32'd0);
        build(4, 5, 60, 6, 0, 60, 9, 0);
        send_frame();
        check_pkt("t6_after", 10, 4'hF, d0, t0);
        check("t6_len", {16'd0, axis_o_length_bytes}, 32'd40);
        rand_rdy = 1'b0;

`ifdef IPV4_DEFRAMER_CHECKSUM_EN
        build(4, 5, 60, 6, 0, 60, 10, 1);
        send_frame();
        check_pkt("t6_csum", 0, 4'h0, d0 + 1, t0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
